// File: rtl/reorder_buffer_pkg.sv
// Shared types and defaults for the reorder buffer: entry layout, tag and
// architectural register widths.
package reorder_buffer_pkg;

   localparam int ROB_DEPTH  = 16;
   localparam int ROB_TAG_W  = $clog2(ROB_DEPTH);
   localparam int ARCH_REG_W = 6;

   typedef logic [ROB_TAG_W-1:0]  rob_tag_t;
   typedef logic [ARCH_REG_W-1:0] arch_reg_t;

   typedef struct packed {
      logic      valid;
      logic      done;
      logic      uses_rw;
      arch_reg_t rw_addr;
      logic      is_branch;
      logic      mispredict;
   } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the reorder buffer. Pointers wrap by
// their power-of-two width; occupancy comes from count, never pointer compare.
module rob_ptr_ctrl
   import reorder_buffer_pkg::*;
#(
   parameter int DEPTH = ROB_DEPTH,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alloc_fire,
   input  logic             retire_fire,
   input  logic             flush,
   output logic [TAG_W-1:0] head,
   output logic [TAG_W-1:0] tail,
   output logic [TAG_W:0]   count,
   output logic             full,
   output logic             empty
);

   logic [TAG_W-1:0] head_reg, head_next;
   logic [TAG_W-1:0] tail_reg, tail_next;
   logic [TAG_W:0]   count_reg, count_next;

   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (flush) begin
         // Everything younger than the retiring branch is squashed, so the
         // buffer restarts empty just past it.
         head_next  = head_reg + 1'b1;
         tail_next  = head_reg + 1'b1;
         count_next = '0;
      end else begin
         if (alloc_fire)
            tail_next = tail_reg + 1'b1;
         if (retire_fire)
            head_next = head_reg + 1'b1;
         count_next = count_reg + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire_fire);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   assign head  = head_reg;
   assign tail  = tail_reg;
   assign count = count_reg;
   assign full  = (count_reg == (TAG_W+1)'(DEPTH));
   assign empty = (count_reg == '0);

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail, completes by tag, retires one
// done head entry per cycle and flushes younger work on a mispredicted branch.
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int DEPTH  = ROB_DEPTH,
   parameter int TAG_W  = $clog2(DEPTH),
   parameter int ARCH_W = ARCH_REG_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alloc_valid,
   output logic              alloc_ready,
   input  logic              alloc_uses_rw,
   input  logic [ARCH_W-1:0] alloc_rw_addr,
   input  logic              alloc_is_branch,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic              complete_valid,
   input  logic [TAG_W-1:0]  complete_tag,
   input  logic              complete_mispredict,
   output logic              retired_uses_rw,
   output logic [ARCH_W-1:0] retired_rw,
   output logic              retire_valid,
   output logic              flush,
   output logic [TAG_W:0]    count,
   output logic              full,
   output logic              empty
);

   logic [TAG_W-1:0] head;
   logic [TAG_W-1:0] tail;
   logic             alloc_fire;
   rob_entry_t       entry_view [DEPTH];
   rob_entry_t       head_entry;

   rob_ptr_ctrl #(
      .DEPTH (DEPTH),
      .TAG_W (TAG_W)
   ) u_ptr_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .alloc_fire  (alloc_fire),
      .retire_fire (retire_valid),
      .flush       (flush),
      .head        (head),
      .tail        (tail),
      .count       (count),
      .full        (full),
      .empty       (empty)
   );

   assign head_entry   = entry_view[head];
   assign retire_valid = head_entry.valid && head_entry.done;
   assign flush        = retire_valid && head_entry.mispredict;
   // A flushing cycle drops any allocate, so it must not look accepted.
   assign alloc_ready  = !full && !flush;
   assign alloc_fire   = alloc_valid && alloc_ready;
   assign alloc_tag    = tail;

   assign retired_uses_rw = retire_valid && head_entry.uses_rw;
   assign retired_rw      = retire_valid ? ARCH_W'(head_entry.rw_addr) : '0;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         rob_entry_t entry_reg;
         logic       hit_alloc;
         logic       hit_complete;
         logic       hit_retire;

         assign hit_alloc    = alloc_fire && (tail == TAG_W'(gi));
         assign hit_complete = complete_valid && (complete_tag == TAG_W'(gi)) && entry_reg.valid;
         assign hit_retire   = retire_valid && (head == TAG_W'(gi));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               entry_reg <= '0;
            end else if (flush) begin
               entry_reg.valid <= 1'b0;
            end else if (hit_alloc) begin
               entry_reg <= '{valid:      1'b1,
                              done:       1'b0,
                              uses_rw:    alloc_uses_rw,
                              rw_addr:    arch_reg_t'(alloc_rw_addr),
                              is_branch:  alloc_is_branch,
                              mispredict: 1'b0};
            end else begin
               if (hit_complete) begin
                  entry_reg.done       <= 1'b1;
                  entry_reg.mispredict <= complete_mispredict && entry_reg.is_branch;
               end
               if (hit_retire)
                  entry_reg.valid <= 1'b0;
            end
         end

         assign entry_view[gi] = entry_reg;
      end
   endgenerate

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a retirement scoreboard queue.
module tb_reorder_buffer;

   localparam int DEPTH  = 16;
   localparam int TAG_W  = 4;
   localparam int ARCH_W = 6;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              alloc_valid;
   logic              alloc_ready;
   logic              alloc_uses_rw;
   logic [ARCH_W-1:0] alloc_rw_addr;
   logic              alloc_is_branch;
   logic [TAG_W-1:0]  alloc_tag;
   logic              complete_valid;
   logic [TAG_W-1:0]  complete_tag;
   logic              complete_mispredict;
   logic              retired_uses_rw;
   logic [ARCH_W-1:0] retired_rw;
   logic              retire_valid;
   logic              flush;
   logic [TAG_W:0]    count;
   logic              full;
   logic              empty;

   always #5 clk = ~clk;

   reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ARCH_W(ARCH_W)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .alloc_valid         (alloc_valid),
      .alloc_ready         (alloc_ready),
      .alloc_uses_rw       (alloc_uses_rw),
      .alloc_rw_addr       (alloc_rw_addr),
      .alloc_is_branch     (alloc_is_branch),
      .alloc_tag           (alloc_tag),
      .complete_valid      (complete_valid),
      .complete_tag        (complete_tag),
      .complete_mispredict (complete_mispredict),
      .retired_uses_rw     (retired_uses_rw),
      .retired_rw          (retired_rw),
      .retire_valid        (retire_valid),
      .flush               (flush),
      .count               (count),
      .full                (full),
      .empty               (empty)
   );

   typedef struct {
      int         tag;
      logic       uses;
      logic [5:0] rw;
      logic       br;
   } exp_t;

   exp_t exp_q[$];
   logic m_done [DEPTH];
   logic m_misp [DEPTH];
   int   m_tail;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   dut_retires = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit pred_flush();
      if (exp_q.size() == 0) return 1'b0;
      return m_done[exp_q[0].tag] && m_misp[exp_q[0].tag];
   endfunction

   // One clock: drive inputs, check outputs against the scoreboard, advance model.
   task automatic cycle(input bit av, input bit uses, input int rw, input bit br,
                        input bit cv, input int ctag, input bit cmisp);
      exp_t f;
      bit   exp_rv, exp_fl, exp_ready;
      f = '{0, 1'b0, 6'd0, 1'b0};
      alloc_valid         = av;
      alloc_uses_rw       = uses;
      alloc_rw_addr       = 6'(rw);
      alloc_is_branch     = br;
      complete_valid      = cv;
      complete_tag        = 4'(ctag);
      complete_mispredict = cmisp;
      exp_rv = 1'b0;
      exp_fl = 1'b0;
      if (exp_q.size() > 0) begin
         f      = exp_q[0];
         exp_rv = m_done[f.tag];
         exp_fl = exp_rv && m_misp[f.tag];
      end
      exp_ready = (exp_q.size() < DEPTH) && !exp_fl;
      #1;
      chk("retire_valid", retire_valid, exp_rv);
      chk("flush", flush, exp_fl);
      chk("retired_uses_rw", retired_uses_rw, exp_rv && f.uses);
      chk("retired_rw", retired_rw, exp_rv ? f.rw : 6'd0);
      chk("alloc_ready", alloc_ready, exp_ready);
      chk("alloc_tag", alloc_tag, m_tail);
      chk("count", count, exp_q.size());
      chk("full", full, exp_q.size() == DEPTH);
      chk("empty", empty, exp_q.size() == 0);
      if (retire_valid === 1'b1) dut_retires++;
      @(posedge clk);
      if (exp_rv)
         $display("[TB] retire tag=%0d uses_rw=%0d rw=%0d flush=%0d", f.tag, f.uses, f.rw, exp_fl);
      if (av)
         $display("[TB] alloc tag=%0d uses_rw=%0d rw=%0d br=%0d accepted=%0d", m_tail, uses, rw, br, exp_ready);
      if (exp_fl) begin
         m_tail = (f.tag + 1) % DEPTH;
         exp_q.delete();
      end else begin
         if (cv)
            foreach (exp_q[i])
               if (exp_q[i].tag == ctag) begin
                  m_done[ctag] = 1'b1;
                  m_misp[ctag] = cmisp && exp_q[i].br;
               end
         if (exp_rv) void'(exp_q.pop_front());
         if (av && exp_ready) begin
            exp_q.push_back('{m_tail, uses, 6'(rw), br});
            m_done[m_tail] = 1'b0;
            m_misp[m_tail] = 1'b0;
            m_tail = (m_tail + 1) % DEPTH;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic drain(input int limit);
      int n = 0;
      while (exp_q.size() > 0 && n < limit) begin
         idle();
         n++;
      end
      chk("drain_empty", empty, 1'b1);
   endtask

   task automatic reset_dut();
      rst_n               = 1'b0;
      alloc_valid         = 1'b0;
      alloc_uses_rw       = 1'b0;
      alloc_rw_addr       = '0;
      alloc_is_branch     = 1'b0;
      complete_valid      = 1'b0;
      complete_tag        = '0;
      complete_mispredict = 1'b0;
      #1;
      chk("rst_retire_valid", retire_valid, 1'b0);
      chk("rst_flush", flush, 1'b0);
      chk("rst_retired_uses_rw", retired_uses_rw, 1'b0);
      chk("rst_retired_rw", retired_rw, 6'd0);
      chk("rst_count", count, 5'd0);
      chk("rst_empty", empty, 1'b1);
      chk("rst_full", full, 1'b0);
      chk("rst_alloc_ready", alloc_ready, 1'b1);
      chk("rst_alloc_tag", alloc_tag, 4'd0);
      exp_q.delete();
      m_tail = 0;
      for (int i = 0; i < DEPTH; i++) begin
         m_done[i] = 1'b0;
         m_misp[i] = 1'b0;
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int base;
      int prev;
      reset_dut();

      // In-order retirement despite out-of-order completion
      base = dut_retires;
      cycle(1, 1, 5, 0, 0, 0, 0);
      cycle(1, 1, 6, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 2, 0);
      cycle(0, 0, 0, 0, 1, 1, 0);
      cycle(0, 0, 0, 0, 1, 0, 0);
      drain(8);
      chk("t1_retires", dut_retires - base, 3);

      // Fill to DEPTH, blocked 17th allocate, one retire reopens
      reset_dut();
      for (int i = 0; i < DEPTH; i++) cycle(1, 1, i, 0, 0, 0, 0);
      chk("t2_full", full, 1'b1);
      chk("t2_count", count, 5'd16);
      cycle(1, 1, 33, 0, 0, 0, 0);
      chk("t2_tail_stays", alloc_tag, 4'd0);
      cycle(0, 0, 0, 0, 1, 0, 0);
      idle();
      chk("t2_ready_again", alloc_ready, 1'b1);
      for (int i = 1; i < DEPTH; i++) cycle(0, 0, 0, 0, 1, i, 0);
      drain(20);

      // Mispredicted branch at tag 4 squashes tags 5..7
      reset_dut();
      base = dut_retires;
      for (int i = 0; i < 8; i++) cycle(1, 1, 10 + i, (i == 4), 0, 0, 0);
      for (int i = 5; i < 8; i++) cycle(0, 0, 0, 0, 1, i, 0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, i, 0);
      cycle(0, 0, 0, 0, 1, 4, 1);
      for (int n = 0; n < 10 && exp_q.size() > 0; n++) begin
         if (pred_flush()) cycle(1, 1, 40, 0, 1, 6, 0);
         else idle();
      end
      chk("t3_count", count, 5'd0);
      chk("t3_tail", alloc_tag, 4'd5);
      chk("t3_retires", dut_retires - base, 5);
      idle();

      // Completion of an unallocated tag while empty
      reset_dut();
      cycle(0, 0, 0, 0, 1, 9, 1);
      idle();
      idle();
      chk("t4_retire_valid", retire_valid, 1'b0);

      // Streaming with one-cycle completion across pointer wrap
      base = dut_retires;
      prev = 0;
      for (int i = 0; i < 40; i++) begin
         int t;
         t = m_tail;
         cycle(1, i % 2, i, 0, i > 0, prev, 0);
         prev = t;
         chk("t5_count_le2", count <= 5'd2, 1'b1);
      end
      cycle(0, 0, 0, 0, 1, prev, 0);
      drain(8);
      chk("t5_retires", dut_retires - base, 40);

      // Asynchronous reset with five entries in flight
      for (int i = 0; i < 5; i++) cycle(1, 1, 20 + i, 0, i == 4, 1, 0);
      chk("t6_count", count, 5'd5);
      reset_dut();
      chk("t6_alloc_tag", alloc_tag, 4'd0);
      cycle(1, 1, 3, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 0, 0);
      drain(6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
